// File: rtl/axi4_lite_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave between NUM_REQ requesters.
// Each requester issues single-beat read/write commands over a req/done port.
// Commands are registered on grant and replayed onto the master interface, so
// AXI address/data stay stable while VALID is high and no VALID depends on READY.
module axi4_lite_rr_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REQ       = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_REQ-1:0]              REQ,
    input  logic [NUM_REQ-1:0]              REQ_WE,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_WDATA,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] REQ_WSTRB,
    output logic [NUM_REQ-1:0]              REQ_DONE,
    output logic [DATA_WIDTH-1:0]           REQ_RDATA,
    output logic [1:0]                      REQ_RESP,
    output logic [NUM_REQ-1:0]              GRANT,
    output logic [ADDRESS_WIDTH-1:0]        M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [ADDRESS_WIDTH-1:0]        M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]           M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    state_t                   state, state_next;
    logic [IW-1:0]            owner, last_grant, pick, cand;
    logic                     pick_valid;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [STRB_WIDTH-1:0]    sel_wstrb;
    logic                     cmd_we;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;
    logic [STRB_WIDTH-1:0]    cmd_wstrb;
    logic                     aw_done, w_done;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic [1:0]               resp_q;
    logic [NUM_REQ-1:0]       owner_onehot;

    // Round-robin search: first set REQ bit starting after last_grant, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((32'(last_grant) + i) % NUM_REQ);
            if (!pick_valid && REQ[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Extract the winning requester's command fields from the packed buses.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_we    = REQ_WE[i];
                sel_addr  = REQ_ADDR[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_wdata = REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb = REQ_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; WRITE leaves once both AW and W have handshaken.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pick_valid) state_next = sel_we ? S_WRITE : S_RADDR;
            S_WRITE: if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
                         state_next = S_WRESP;
            S_WRESP: if (M_AXI_BVALID)  state_next = S_DONE;
            S_RADDR: if (M_AXI_ARREADY) state_next = S_RDATA;
            S_RDATA: if (M_AXI_RVALID)  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command capture, handshake tracking, response capture and grant history.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            owner      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_wstrb  <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= '0;
        end else begin
            case (state)
                S_IDLE: if (pick_valid) begin
                    owner     <= pick;
                    cmd_we    <= sel_we;
                    cmd_addr  <= sel_addr;
                    cmd_wdata <= sel_wdata;
                    cmd_wstrb <= sel_wstrb;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    rdata_q   <= '0;
                    resp_q    <= '0;
                end
                S_WRITE: begin
                    if (M_AXI_AWREADY) aw_done <= 1'b1;
                    if (M_AXI_WREADY)  w_done  <= 1'b1;
                end
                S_WRESP: if (M_AXI_BVALID) resp_q <= M_AXI_BRESP;
                S_RDATA: if (M_AXI_RVALID) begin
                    rdata_q <= M_AXI_RDATA;
                    resp_q  <= M_AXI_RRESP;
                end
                S_DONE:  last_grant <= owner;
                default: ;
            endcase
        end
    end

    assign owner_onehot  = NUM_REQ'(1) << owner;

    assign GRANT         = (state != S_IDLE) ? owner_onehot : '0;
    assign REQ_DONE      = (state == S_DONE) ? owner_onehot : '0;
    assign REQ_RDATA     = rdata_q;
    assign REQ_RESP      = resp_q;

    assign M_AXI_AWADDR  = cmd_addr;
    assign M_AXI_ARADDR  = cmd_addr;
    assign M_AXI_WDATA   = cmd_wdata;
    assign M_AXI_WSTRB   = cmd_wstrb;
    assign M_AXI_AWVALID = (state == S_WRITE) && !aw_done;
    assign M_AXI_WVALID  = (state == S_WRITE) && !w_done;
    assign M_AXI_BREADY  = (state == S_WRESP);
    assign M_AXI_ARVALID = (state == S_RADDR);
    assign M_AXI_RREADY  = (state == S_RDATA);

    logic unused_cmd_we;
    assign unused_cmd_we = cmd_we;

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// Self-checking bench for axi4_lite_rr_arbiter: table of single transactions
// against a delay-configurable slave model, plus reset and contention sequences.
module tb_axi4_lite_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            areset;
    logic [NR-1:0]   req, req_we, req_done, grant;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*DW/8-1:0] req_wstrb;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_resp;
    logic [AW-1:0]   awaddr, araddr;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;

    always #5 clk = ~clk;

    axi4_lite_rr_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .ACLK(clk), .ARESET(areset),
        .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .REQ_WSTRB(req_wstrb), .REQ_DONE(req_done), .REQ_RDATA(req_rdata),
        .REQ_RESP(req_resp), .GRANT(grant),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct {
        int unsigned rid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        logic [31:0] s_rdata;
        logic [1:0]  s_resp;
        int unsigned a_dly;
        int unsigned w_dly;
        int unsigned r_dly;
        int unsigned exp_cyc;
        logic [1:0]  exp_done;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[6];
    int checks = 0;
    int errors = 0;

    // Slave model state
    int unsigned m_adly, m_wdly, m_rdly;
    int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_hs, w_hs, ar_hs, b_act, b_fin, r_act;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_act = 0; b_fin = 0; r_act = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    endtask

    // Decide slave inputs for the current cycle, then record what the next edge completes.
    task automatic slave_step();
        awready = awvalid && (aw_cnt >= m_adly);
        wready  = wvalid  && (w_cnt  >= m_wdly);
        arready = arvalid && (ar_cnt >= m_adly);
        bvalid  = b_act && (b_cnt >= m_rdly);
        rvalid  = r_act && (r_cnt >= m_rdly);
        if (awvalid) aw_cnt++;
        if (wvalid)  w_cnt++;
        if (arvalid) ar_cnt++;
        if (b_act)   b_cnt++;
        if (r_act)   r_cnt++;
        if (bvalid && bready) begin b_act = 0; b_fin = 1; end
        if (rvalid && rready) r_act = 0;
        if (awvalid && awready) aw_hs = 1;
        if (wvalid && wready)   w_hs = 1;
        if (aw_hs && w_hs && !b_act && !b_fin) begin b_act = 1; b_cnt = 0; end
        if (arvalid && arready) begin ar_hs = 1; r_act = 1; r_cnt = 0; end
    endtask

    task automatic run_vec(input vec_t v);
        bit done_seen;
        logic [4:0] exp_hs;
        model_clear();
        m_adly = v.a_dly; m_wdly = v.w_dly; m_rdly = v.r_dly;
        rdata = v.s_rdata; rresp = v.s_resp; bresp = v.s_resp;
        req = '0;
        req[v.rid] = 1'b1;
        req_we[v.rid] = v.we;
        req_addr[v.rid*AW +: AW] = v.addr;
        req_wdata[v.rid*DW +: DW] = v.wdat;
        req_wstrb[v.rid*4 +: 4] = v.strb;
        done_seen = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (c == 1) begin
                chk("grant", grant, v.exp_done);
                if (v.we) begin
                    chk("awaddr", awaddr, v.addr);
                    chk("wdata", wdata, v.wdat);
                    chk("wstrb", wstrb, v.strb);
                end else begin
                    chk("araddr", araddr, v.addr);
                end
            end
            exp_hs = {v.we && c > 0 && !aw_hs, v.we && c > 0 && !w_hs, b_act,
                      !v.we && c > 0 && !ar_hs, r_act};
            chk("valid_ready", {awvalid, wvalid, bready, arvalid, rready}, exp_hs);
            if (req_done !== '0) begin
                done_seen = 1;
                chk("done_cycle", c, v.exp_cyc);
                chk("req_done", req_done, v.exp_done);
                chk("req_rdata", req_rdata, v.exp_rdata);
                chk("req_resp", req_resp, v.exp_resp);
            end
            slave_step();
            @(posedge clk); #1;
        end
        req = '0;
        model_clear();
        if (!done_seen) chk("done_timeout", 1, 0);
    endtask

    // REQ=11 held: expect four completions alternating, starting from requester 0.
    task automatic run_contention();
        logic [1:0] order [4];
        int k;
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
        model_clear();
        m_adly = 0; m_wdly = 0; m_rdly = 0;
        rdata = 32'h5555_AAAA; rresp = 2'b00;
        req_we = 2'b00;
        req_addr = {32'h0000_0020, 32'h0000_0010};
        req = 2'b11;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            chk("onehot", {$onehot0(grant), $onehot0(req_done)}, 2'b11);
            if (arvalid) chk("cont_araddr", araddr, (order[k] == 2'b01) ? 32'h10 : 32'h20);
            if (req_done !== '0) begin
                chk("cont_order", req_done, order[k]);
                chk("cont_rdata", req_rdata, 32'h5555_AAAA);
                k++;
                model_clear();
            end
            slave_step();
            @(posedge clk); #1;
        end
        req = '0;
        chk("cont_count", k, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 0, 0, 0, 3, 2'b01, 32'h0, 2'b00};
        vecs[1] = '{1, 1'b0, 32'h08, 32'h0, 4'h0, 32'h12345678, 2'b00, 0, 0, 0, 3, 2'b10, 32'h12345678, 2'b00};
        vecs[2] = '{0, 1'b1, 32'h0C, 32'h000000FF, 4'h3, 32'h99999999, 2'b01, 0, 3, 0, 6, 2'b01, 32'h0, 2'b01};
        vecs[3] = '{1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A50F0F, 2'b10, 0, 0, 6, 9, 2'b10, 32'hA5A50F0F, 2'b10};
        vecs[4] = '{1, 1'b1, 32'h14, 32'h01020304, 4'hC, 32'h77777777, 2'b10, 2, 0, 2, 7, 2'b10, 32'h0, 2'b10};
        vecs[5] = '{0, 1'b0, 32'h18, 32'h0, 4'h0, 32'hCAFEF00D, 2'b11, 2, 0, 1, 6, 2'b01, 32'hCAFEF00D, 2'b11};

        areset = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rdata = '0; rresp = '0; bresp = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_ready", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_done", req_done, 2'b00);
        chk("rst_rdata_resp", {req_rdata, req_resp}, 34'h0);
        areset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a write whose slave never accepts.
        model_clear();
        m_adly = 50; m_wdly = 50; m_rdly = 0;
        req = 2'b01; req_we = 2'b01;
        req_addr[0 +: AW] = 32'h40; req_wdata[0 +: DW] = 32'h11223344; req_wstrb[0 +: 4] = 4'hF;
        slave_step();
        @(posedge clk); #1;
        chk("mid_awvalid", {awvalid, wvalid, grant}, 4'b1101);
        slave_step();
        @(posedge clk); #1;
        areset = 1'b1;
        slave_step();
        @(posedge clk); #1;
        chk("mid_rst_valid_ready", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("mid_rst_grant", {grant, req_done}, 4'b0);
        areset = 1'b0;
        run_contention();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_rr_arbiter.md
# axi4_lite_rr_arbiter

Round-robin arbiter that shares one AXI4-Lite slave (the register/memory slave) between NUM_REQ internal requesters. Each requester issues single-beat read or write commands on a simple req/done port. The arbiter serializes them onto one AXI4-Lite master interface and returns read data and response per transaction. It sits between the block-level controllers and the AXI4-Lite slave.

## Interface
- ADDRESS_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (multiple of 8)
- NUM_REQ, 2, number of requesters (≥2)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  per-requester command request; held until that requester's DONE
- REQ_WE  in  NUM_REQ  1 = write, 0 = read
- REQ_ADDR  in  NUM_REQ*ADDRESS_WIDTH  packed addresses, requester i at [i*AW +: AW]
- REQ_WDATA  in  NUM_REQ*DATA_WIDTH  packed write data
- REQ_WSTRB  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes
- REQ_DONE  out  NUM_REQ  one-cycle completion pulse to owning requester
- REQ_RDATA  out  DATA_WIDTH  read data; valid while REQ_DONE high
- REQ_RESP  out  2  RRESP/BRESP of completed transaction; valid while REQ_DONE high
- GRANT  out  NUM_REQ  one-hot current owner, 0 when idle
- M_AXI_AWADDR out AW, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1
- M_AXI_WDATA out DW, M_AXI_WSTRB out DW/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out AW, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1
- M_AXI_RDATA in DW, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, DONE.
- IDLE: if any REQ bit is set, select the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap-around. Register the winner's WE/ADDR/WDATA/WSTRB and set GRANT. Go to WRITE if WE=1, else RADDR. No REQ: stay.
- WRITE: AWVALID and WVALID both asserted on entry. Each deasserts independently after its own handshake (VALID&READY at an edge); aw_done/w_done flags track this. Both handshakes in the same cycle is legal. Once both are done -> WRESP.
- WRESP: BREADY=1; on BVALID, capture BRESP -> DONE.
- RADDR: ARVALID=1 until ARREADY -> RDATA.
- RDATA: RREADY=1; on RVALID, capture RDATA, RRESP -> DONE.
- DONE: REQ_DONE[owner]=1 for exactly one cycle, with REQ_RDATA/REQ_RESP valid. Update last_grant=owner, clear GRANT, -> IDLE. REQ is ignored in DONE.
- Requester protocol: hold REQ and its command fields stable from assertion through its DONE cycle. Deassert REQ on the edge ending the DONE cycle, or leave it high to request another transaction.
- AXI address/data outputs come from registered command only and are stable while VALID is high. No VALID depends combinationally on a READY.
- REQ_RDATA is 0 after a write. BRESP/RRESP pass through unmodified; the arbiter never generates errors.
- Fairness: a requester holding REQ is granted within NUM_REQ transactions.

## Timing
- Reset values (ARESET high at an edge): state IDLE, all M_AXI VALID/READY 0, GRANT 0, REQ_DONE 0, REQ_RDATA 0, REQ_RESP 0, last_grant = NUM_REQ-1 (requester 0 wins first).
- Reset mid-transaction: return to IDLE at the next edge and drop all VALID/READY. The slave is reset in the same cycle by system design.
- Arbiter overhead: 1 cycle IDLE->issue, 1 cycle DONE. With a zero-wait slave (READY high, response next cycle): write REQ at cycle 0 -> AW/W valid cycle 1 -> BVALID cycle 2 -> REQ_DONE cycle 3. Read has the same timing.
- Back-to-back: a new grant is possible in the IDLE cycle directly after DONE (minimum 4-cycle transaction spacing).
- Slave stalls extend WRITE/WRESP/RADDR/RDATA indefinitely. There is no timeout.

## Test plan
- Single write: req0 WE=1 ADDR=0x04 WDATA=0xDEADBEEF WSTRB=0xF, slave zero-wait, BRESP=00 -> AW/W valid cycle 1 with those values, REQ_DONE=01 cycle 3, REQ_RESP=00.
- Single read: req1 ADDR=0x08, slave returns 0x12345678 RRESP=00 -> ARADDR=0x08, REQ_DONE=10, REQ_RDATA=0x12345678.
- Contention: REQ=11 held for 4 transactions -> grant order 0,1,0,1, GRANT one-hot each time, no overlap of DONE pulses.
- Handshake skew: AWREADY at cycle 1, WREADY delayed to cycle 4 -> AWVALID drops after cycle 1, WVALID held to cycle 4, BREADY only from cycle 5.
- Backpressure and error: RVALID delayed 6 cycles with RRESP=10 -> RREADY held high throughout, REQ_RESP=10 on DONE.
- Reset mid-write: ARESET during WRITE with AWVALID=1 -> next cycle all VALID/READY 0, GRANT 0, then requester 0 is granted first after release.
